// File: rtl/lsu_pkg.sv
//------------------------------------------------------------------------------
// Module   : lsu_pkg
// Purpose  : Shared size encodings, FSM state type and data width for the LSU.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package lsu_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LD_READ   = 3'd1,
    LD_FORMAT = 3'd2,
    ST_WRITE  = 3'd3,
    RMW_READ  = 3'd4,
    RMW_MERGE = 3'd5
  } lsu_state_t;

endpackage

`default_nettype wire

// File: rtl/lsu_lane_align.sv
//------------------------------------------------------------------------------
// Module   : lsu_lane_align
// Purpose  : Combinational byte/half lane extraction with extension for loads,
//            and lane merge into an old word for sub-word stores.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]        i_size,
  input  logic [1:0]        i_offset,
  input  logic              i_signed,
  input  logic [DATA_W-1:0] i_old_word,
  input  logic [DATA_W-1:0] i_new_data,
  output logic [DATA_W-1:0] o_load_data,
  output logic [DATA_W-1:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_old_word[{i_offset, 3'b000} +: 8];
    w_half = i_offset[1] ? i_old_word[31:16] : i_old_word[15:0];

    case (i_size)
      SZ_BYTE: o_load_data = {{24{i_signed & w_byte[7]}}, w_byte};
      SZ_HALF: o_load_data = {{16{i_signed & w_half[15]}}, w_half};
      default: o_load_data = i_old_word;
    endcase

    o_merged = i_old_word;
    case (i_size)
      SZ_BYTE: o_merged[{i_offset, 3'b000} +: 8] = i_new_data[7:0];
      SZ_HALF: o_merged[{i_offset[1], 4'b0000} +: 16] = i_new_data[15:0];
      default: o_merged = i_new_data;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
//------------------------------------------------------------------------------
// Module   : load_store_unit
// Purpose  : MEM-stage load/store controller with read-modify-write sub-word
//            stores. Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses
//            instead of masking the low address bits.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module load_store_unit
  import lsu_pkg::*;
#(
  parameter int          WORD_ADDR_W = 6,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                   Clock,
  input  logic                   Reset_n,
  input  logic                   ReqValid,
  output logic                   ReqReady,
  input  logic                   ReqWrite,
  input  logic [1:0]             ReqSize,
  input  logic                   ReqSigned,
  input  logic [31:0]            ReqAddress,
  input  logic [DATA_W-1:0]      ReqWriteData,
  output logic                   RespValid,
  output logic                   RespError,
  output logic [DATA_W-1:0]      LoadData,
  output logic [WORD_ADDR_W-1:0] MemAddress,
  output logic [DATA_W-1:0]      MemWriteData,
  output logic                   MemRead,
  output logic                   MemWrite,
  input  logic [DATA_W-1:0]      MemReadData
);

  localparam logic [32:0] c_SPAN = 33'd4 << WORD_ADDR_W;

  lsu_state_t             r_state;
  logic                   r_write;
  logic [1:0]             r_size;
  logic                   r_signed;
  logic [1:0]             r_offset;
  logic [WORD_ADDR_W-1:0] r_word_addr;
  logic [DATA_W-1:0]      r_wdata;
  logic                   r_resp_valid;
  logic                   r_resp_error;
  logic [DATA_W-1:0]      r_load_data;

  logic [31:0]       w_off;
  logic              w_range_err;
  logic              w_err;
  logic [1:0]        w_lane_off;
  logic [DATA_W-1:0] w_load;
  logic [DATA_W-1:0] w_merged;

  assign w_off       = ReqAddress - BASE_ADDR;
  assign w_range_err = (ReqAddress < BASE_ADDR) || ({1'b0, w_off} >= c_SPAN);

`ifdef LSU_MISALIGN_TRAP_EN
  logic w_misalign;
  assign w_misalign = ((ReqSize == SZ_HALF) && w_off[0]) ||
                      ((ReqSize == SZ_WORD) && (w_off[1:0] != 2'b00));
  assign w_err      = (ReqSize == 2'b11) || w_range_err || w_misalign;
  assign w_lane_off = w_off[1:0];
`else
  assign w_err = (ReqSize == 2'b11) || w_range_err;
  always_comb begin
    case (ReqSize)
      SZ_HALF: w_lane_off = {w_off[1], 1'b0};
      SZ_WORD: w_lane_off = 2'b00;
      default: w_lane_off = w_off[1:0];
    endcase
  end
`endif

  lsu_lane_align u_lane_align (
    .i_size      (r_size),
    .i_offset    (r_offset),
    .i_signed    (r_signed),
    .i_old_word  (MemReadData),
    .i_new_data  (r_wdata),
    .o_load_data (w_load),
    .o_merged    (w_merged)
  );

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      r_state      <= IDLE;
      r_write      <= 1'b0;
      r_size       <= 2'b00;
      r_signed     <= 1'b0;
      r_offset     <= 2'b00;
      r_word_addr  <= '0;
      r_wdata      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_error <= 1'b0;
      r_load_data  <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_error <= 1'b0;
      case (r_state)
        IDLE: begin
          if (ReqValid) begin
            r_write     <= ReqWrite;
            r_size      <= ReqSize;
            r_signed    <= ReqSigned;
            r_offset    <= w_lane_off;
            r_word_addr <= w_off[WORD_ADDR_W+1:2];
            r_wdata     <= ReqWriteData;
            if (w_err) begin
              r_resp_valid <= 1'b1;
              r_resp_error <= 1'b1;
              r_load_data  <= '0;
            end else if (!ReqWrite) begin
              r_state <= LD_READ;
            end else if (ReqSize == SZ_WORD) begin
              r_state <= ST_WRITE;
            end else begin
              r_state <= RMW_READ;
            end
          end
        end
        LD_READ:   r_state <= LD_FORMAT;
        LD_FORMAT: begin
          r_load_data  <= r_write ? '0 : w_load;
          r_resp_valid <= 1'b1;
          r_state      <= IDLE;
        end
        RMW_READ:  r_state <= RMW_MERGE;
        ST_WRITE, RMW_MERGE: begin
          r_load_data  <= '0;
          r_resp_valid <= 1'b1;
          r_state      <= IDLE;
        end
        default:   r_state <= IDLE;
      endcase
    end
  end

  // Gating with Reset_n keeps a falling-edge write from landing while in reset.
  assign MemRead      = Reset_n && ((r_state == LD_READ) || (r_state == RMW_READ));
  assign MemWrite     = Reset_n && ((r_state == ST_WRITE) || (r_state == RMW_MERGE));
  assign MemAddress   = r_word_addr;
  assign MemWriteData = (r_state == RMW_MERGE) ? w_merged : r_wdata;

  assign ReqReady  = (r_state == IDLE);
  assign RespValid = r_resp_valid;
  assign RespError = r_resp_error;
  assign LoadData  = r_load_data;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
//------------------------------------------------------------------------------
// Module   : tb_load_store_unit
// Purpose  : Scoreboard testbench for load_store_unit with a word memory model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_load_store_unit;

  logic        Clock = 1'b0;
  logic        Reset_n = 1'b0;
  logic        ReqValid = 1'b0;
  logic        ReqReady;
  logic        ReqWrite = 1'b0;
  logic [1:0]  ReqSize = 2'b00;
  logic        ReqSigned = 1'b0;
  logic [31:0] ReqAddress = '0;
  logic [31:0] ReqWriteData = '0;
  logic        RespValid;
  logic        RespError;
  logic [31:0] LoadData;
  logic [5:0]  MemAddress;
  logic [31:0] MemWriteData;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] MemReadData = '0;

  load_store_unit #(.WORD_ADDR_W(6), .BASE_ADDR(32'h0)) dut (
    .Clock(Clock), .Reset_n(Reset_n),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
    .ReqSize(ReqSize), .ReqSigned(ReqSigned), .ReqAddress(ReqAddress),
    .ReqWriteData(ReqWriteData), .RespValid(RespValid), .RespError(RespError),
    .LoadData(LoadData), .MemAddress(MemAddress), .MemWriteData(MemWriteData),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemReadData(MemReadData)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          acc;
    int          lat;
    string       name;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] mem [64];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          last_rd_cyc = 0;
  int          last_wr_cyc = 0;

  always @(posedge Clock) cyc <= cyc + 1;

  // Memory model: synchronous read on the rising edge, write on the falling edge.
  always @(posedge Clock) if (MemRead) MemReadData <= mem[MemAddress];
  always @(negedge Clock) begin
    if (MemWrite) begin
      mem[MemAddress] <= MemWriteData;
      wr_cnt      <= wr_cnt + 1;
      last_wr_cyc <= cyc;
    end
    if (MemRead) begin
      rd_cnt      <= rd_cnt + 1;
      last_rd_cyc <= cyc;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per response pulse.
  always @(negedge Clock) begin
    if (RespValid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got RespValid=1 expected no response");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check({e.name, "_err"}, {31'd0, RespError}, {31'd0, e.err});
        check({e.name, "_data"}, LoadData, e.data);
        if (e.lat != 0) check({e.name, "_lat"}, cyc - e.acc, e.lat);
      end
    end
  end

  // Called at a falling edge; returns at the falling edge right after the accept.
  task automatic issue(input bit wr, input logic [1:0] sz, input bit sg,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input bit exp_err, input logic [31:0] exp_data,
                       input int lat, input bit push, input string name);
    int guard;
    exp_t e;
    ReqWrite = wr; ReqSize = sz; ReqSigned = sg;
    ReqAddress = addr; ReqWriteData = wdata; ReqValid = 1'b1;
    guard = 0;
    while (!ReqReady && guard < 50) begin
      @(negedge Clock);
      guard++;
    end
    if (!ReqReady) begin
      checks++;
      errors++;
      $display("FAIL %s_accept: got ReqReady=0 expected 1 within 50 cycles", name);
    end
    if (push) begin
      e.err = exp_err; e.data = exp_data; e.acc = cyc; e.lat = lat; e.name = name;
      sb_q.push_back(e);
    end
    @(negedge Clock);
    ReqValid = 1'b0;
  endtask

  task automatic drain(input string name);
    int guard;
    guard = 0;
    while (sb_q.size() != 0 && guard < 50) begin
      @(negedge Clock);
      guard++;
    end
    @(negedge Clock);
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_drain: got %0d pending responses expected 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd0, wr0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[8]  = 32'h80FF_7F01;
    mem[10] = 32'h0102_0304;
    mem[12] = 32'hA5A5_A5A5;
    mem[63] = 32'hCAFE_F00D;

    repeat (3) @(negedge Clock);
    Reset_n = 1'b1;
    check("rst_ready", {31'd0, ReqReady}, 32'd1);
    check("rst_respvalid", {31'd0, RespValid}, 32'd0);
    check("rst_loaddata", LoadData, 32'd0);
    check("rst_memrd_memwr", {30'd0, MemRead, MemWrite}, 32'd0);

    // word store then load back
    issue(1, 2'b10, 0, 32'h10, 32'hDEAD_BEEF, 0, 32'h0, 0, 1, "st_word");
    issue(0, 2'b10, 0, 32'h10, 32'h0, 0, 32'hDEAD_BEEF, 3, 1, "ld_word");
    drain("word");

    // byte RMW store into a known word
    issue(1, 2'b10, 0, 32'h10, 32'h1122_3344, 0, 32'h0, 0, 1, "st_init");
    drain("init");
    rd0 = rd_cnt; wr0 = wr_cnt;
    issue(1, 2'b00, 0, 32'h11, 32'hFFFF_FF5A, 0, 32'h0, 0, 1, "st_byte");
    drain("byte");
    check("rmw_reads", rd_cnt - rd0, 32'd1);
    check("rmw_writes", wr_cnt - wr0, 32'd1);
    check("rmw_order", last_wr_cyc - last_rd_cyc, 32'd1);
    issue(0, 2'b10, 0, 32'h10, 32'h0, 0, 32'h1122_5A44, 3, 1, "ld_after_byte");

    // sign/zero extension, back-to-back issue
    issue(0, 2'b00, 1, 32'h23, 32'h0, 0, 32'hFFFF_FF80, 3, 1, "ld_sbyte");
    issue(0, 2'b00, 0, 32'h23, 32'h0, 0, 32'h0000_0080, 3, 1, "ld_ubyte");
    issue(0, 2'b01, 1, 32'h22, 32'h0, 0, 32'hFFFF_80FF, 3, 1, "ld_shalf");
    issue(0, 2'b01, 0, 32'h20, 32'h0, 0, 32'h0000_7F01, 3, 1, "ld_uhalf");
    issue(0, 2'b00, 1, 32'h21, 32'h0, 0, 32'h0000_007F, 3, 1, "ld_sbyte_pos");

    // half RMW store into upper lane
    issue(1, 2'b01, 0, 32'h2A, 32'h1234_ABCD, 0, 32'h0, 0, 1, "st_half");
    issue(0, 2'b10, 0, 32'h28, 32'h0, 0, 32'hABCD_0304, 3, 1, "ld_after_half");
    issue(0, 2'b10, 0, 32'hFC, 32'h0, 0, 32'hCAFE_F00D, 3, 1, "ld_top_word");
    drain("lanes");

    // error cases must not touch memory
    rd0 = rd_cnt; wr0 = wr_cnt;
    issue(0, 2'b10, 0, 32'h102, 32'h0, 1, 32'h0, 1, 1, "ld_range");
    issue(0, 2'b11, 0, 32'h10, 32'h0, 1, 32'h0, 1, 1, "ld_size11");
    issue(1, 2'b10, 0, 32'h100, 32'h5555_5555, 1, 32'h0, 1, 1, "st_range");
    drain("errors");
    check("err_no_reads", rd_cnt - rd0, 32'd0);
    check("err_no_writes", wr_cnt - wr0, 32'd0);

`ifdef LSU_MISALIGN_TRAP_EN
    issue(0, 2'b01, 0, 32'h11, 32'h0, 1, 32'h0, 1, 1, "ld_misalign");
`else
    issue(0, 2'b01, 0, 32'h11, 32'h0, 0, 32'h0000_5A44, 3, 1, "ld_misalign");
`endif
    drain("misalign");

    // reset during the merge cycle of a byte RMW
    wr0 = wr_cnt;
    issue(1, 2'b00, 0, 32'h30, 32'h0000_00FF, 0, 32'h0, 0, 0, "st_abort");
    @(posedge Clock);
    #1 Reset_n = 1'b0;
    @(posedge Clock);
    #1 Reset_n = 1'b1;
    @(negedge Clock);
    check("abort_ready", {31'd0, ReqReady}, 32'd1);
    check("abort_respvalid", {31'd0, RespValid}, 32'd0);
    repeat (3) @(negedge Clock);
    check("abort_mem", mem[12], 32'hA5A5_A5A5);
    check("abort_writes", wr_cnt - wr0, 32'd0);
    issue(0, 2'b10, 0, 32'h30, 32'h0, 0, 32'hA5A5_A5A5, 3, 1, "ld_after_abort");
    drain("abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
